p405s_dcu_tag_arb: RTL and testbench

P405S_DCU_TAG_ARB -- requirements
Module: p405s_dcu_tag_arb

---
 rtl/p405s_dcu_tag_arb.sv | 144 ++++++++++++++
 tb/tb_p405s_dcu_tag_arb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/p405s_dcu_tag_arb.sv
// Data-cache tag array arbiter: linefill writes, CPU lookups and a 256-set flash-invalidate sweep
// share one tag port; every array-side control is registered one cycle after its grant.
module p405s_dcu_tag_arb (
  input  logic        CB,
  input  logic        resetN,
  input  logic        lkupReq,
  input  logic [0:9]  lkupIndex,
  output logic        lkupGnt,
  output logic        lkupRdy,
  input  logic        fillReq,
  input  logic [0:9]  fillIndex,
  input  logic [0:20] fillTag,
  input  logic        fillWay,
  input  logic        fillValid,
  input  logic        fillU0,
  output logic        fillAck,
  input  logic        sweepStart,
  output logic        sweepBusy,
  output logic        sweepDone,
  input  logic        bist_mode,
  output logic [0:9]  tagIndex,
  output logic [0:20] dataIn,
  output logic        newValidIn,
  output logic        wbU0AttrL1,
  output logic        tagReadNotWrite_In,
  output logic        tagReadWriteCycle_In,
  output logic        writeTagA0,
  output logic        writeTagA1,
  output logic        writeTagB0,
  output logic        writeTagB1
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t     state, stateNext;
  logic [7:0] cnt, cntNext;
  logic       pend, pendNext;
  logic       sweepStep;
  logic       gntD1;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pendNext  = pend;
    lkupGnt   = 1'b0;
    fillAck   = 1'b0;
    sweepStep = 1'b0;
    case (state)
      IDLE: begin
        // sweepBusy is still high for the cycle after DRAIN, keeping the port quiet until sweepDone
        if (!sweepBusy) begin
          if (bist_mode) begin
            if (sweepStart) pendNext = 1'b1;
          end else begin
            if (fillReq) fillAck = 1'b1;
            else if (!(sweepStart || pend)) lkupGnt = lkupReq;
            if (sweepStart || pend) begin
              stateNext = SWEEP;
              pendNext  = 1'b0;
            end
          end
        end
      end
      SWEEP: begin
        if (!bist_mode) begin
          sweepStep = 1'b1;
          cntNext   = cnt + 8'd1;
          if (cnt == 8'hFF) stateNext = DRAIN;
        end
      end
      DRAIN:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CB or negedge resetN) begin
    if (!resetN) begin
      state                <= IDLE;
      cnt                  <= '0;
      pend                 <= 1'b0;
      sweepBusy            <= 1'b0;
      sweepDone            <= 1'b0;
      gntD1                <= 1'b0;
      lkupRdy              <= 1'b0;
      tagIndex             <= '0;
      dataIn               <= '0;
      newValidIn           <= 1'b0;
      wbU0AttrL1           <= 1'b0;
      tagReadNotWrite_In   <= 1'b1;
      tagReadWriteCycle_In <= 1'b0;
      writeTagA0           <= 1'b0;
      writeTagA1           <= 1'b0;
      writeTagB0           <= 1'b0;
      writeTagB1           <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      pend      <= pendNext;
      sweepBusy <= (stateNext != IDLE) || (state == DRAIN);
      sweepDone <= (state == DRAIN);
      gntD1     <= lkupGnt;
      lkupRdy   <= gntD1;
      if (fillAck) begin
        tagIndex             <= fillIndex;
        dataIn               <= fillTag;
        newValidIn           <= fillValid;
        wbU0AttrL1           <= fillU0;
        tagReadNotWrite_In   <= 1'b0;
        tagReadWriteCycle_In <= 1'b1;
        writeTagA0           <= ~fillWay;
        writeTagA1           <= ~fillWay;
        writeTagB0           <= fillWay;
        writeTagB1           <= fillWay;
      end else if (lkupGnt) begin
        tagIndex             <= lkupIndex;
        tagReadNotWrite_In   <= 1'b1;
        tagReadWriteCycle_In <= 1'b1;
        writeTagA0           <= 1'b0;
        writeTagA1           <= 1'b0;
        writeTagB0           <= 1'b0;
        writeTagB1           <= 1'b0;
      end else if (sweepStep) begin
        tagIndex             <= {1'b0, cnt, 1'b0};
        dataIn               <= '0;
        newValidIn           <= 1'b0;
        wbU0AttrL1           <= 1'b0;
        tagReadNotWrite_In   <= 1'b0;
        tagReadWriteCycle_In <= 1'b1;
        writeTagA0           <= 1'b1;
        writeTagA1           <= 1'b1;
        writeTagB0           <= 1'b1;
        writeTagB1           <= 1'b1;
      end else begin
        tagReadNotWrite_In   <= 1'b1;
        tagReadWriteCycle_In <= 1'b0;
        writeTagA0           <= 1'b0;
        writeTagA1           <= 1'b0;
        writeTagB0           <= 1'b0;
        writeTagB1           <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_p405s_dcu_tag_arb.sv
// Directed bench for p405s_dcu_tag_arb: vector table for single-cycle arbitration plus sweep sequences.
module tb_p405s_dcu_tag_arb;

  logic        CB = 1'b0;
  logic        resetN = 1'b1;
  logic        lkupReq = 1'b0, fillReq = 1'b0, sweepStart = 1'b0, bist_mode = 1'b0;
  logic [0:9]  lkupIndex = '0, fillIndex = '0;
  logic [0:20] fillTag = '0;
  logic        fillWay = 1'b0, fillValid = 1'b0, fillU0 = 1'b0;
  logic        lkupGnt, lkupRdy, fillAck, sweepBusy, sweepDone;
  logic [0:9]  tagIndex;
  logic [0:20] dataIn;
  logic        newValidIn, wbU0AttrL1, tagReadNotWrite_In, tagReadWriteCycle_In;
  logic        writeTagA0, writeTagA1, writeTagB0, writeTagB1;

  int checks = 0;
  int errors = 0;

  localparam logic [41:0] RST_EXP = {10'h0, 21'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 3'b000};

  always #5 CB = ~CB;

  p405s_dcu_tag_arb dut (
    .CB(CB), .resetN(resetN),
    .lkupReq(lkupReq), .lkupIndex(lkupIndex), .lkupGnt(lkupGnt), .lkupRdy(lkupRdy),
    .fillReq(fillReq), .fillIndex(fillIndex), .fillTag(fillTag), .fillWay(fillWay),
    .fillValid(fillValid), .fillU0(fillU0), .fillAck(fillAck),
    .sweepStart(sweepStart), .sweepBusy(sweepBusy), .sweepDone(sweepDone),
    .bist_mode(bist_mode),
    .tagIndex(tagIndex), .dataIn(dataIn), .newValidIn(newValidIn), .wbU0AttrL1(wbU0AttrL1),
    .tagReadNotWrite_In(tagReadNotWrite_In), .tagReadWriteCycle_In(tagReadWriteCycle_In),
    .writeTagA0(writeTagA0), .writeTagA1(writeTagA1), .writeTagB0(writeTagB0), .writeTagB1(writeTagB1)
  );

  typedef struct {
    logic lr; logic [9:0] li; logic fr; logic [9:0] fi; logic [20:0] ft;
    logic fw, fv, fu, bist;
    logic eGnt, eAck, eRdy;
    logic [9:0] eTag; logic [20:0] eData; logic eNv, eU0, eRnw, eRwc; logic [3:0] eWr;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [38:0] arrNow();
    return {tagIndex, dataIn, newValidIn, wbU0AttrL1, tagReadNotWrite_In, tagReadWriteCycle_In,
            writeTagA0, writeTagA1, writeTagB0, writeTagB1};
  endfunction

  function automatic logic [41:0] rstBus();
    return {arrNow(), lkupRdy, sweepBusy, sweepDone};
  endfunction

  task automatic idleIn();
    lkupReq = 1'b0; fillReq = 1'b0; sweepStart = 1'b0; bist_mode = 1'b0;
  endtask

  // mode 0: plain sweep, 1: BIST pause at cnt 100, 2: reset at cnt 50
  task automatic sweepRun(input int mode, input logic withFill, input logic holdLkup);
    int writes = 0, busyCyc = 0, doneCnt = 0, doneCyc = -1, lastWr = -1;
    int idxErr = 0, gntErr = 0, anom = 0, bistErr = 0, bistLeft = 0, quiet = 0;
    logic bistUsed = 1'b0, finished = 1'b0;
    logic [7:0] expCnt = 8'd0;
    sweepStart = 1'b1;
    lkupReq = holdLkup; lkupIndex = 10'h2D2;
    if (withFill) begin
      fillReq = 1'b1; fillIndex = 10'h055; fillTag = 21'h0ABCDE;
      fillWay = 1'b0; fillValid = 1'b1; fillU0 = 1'b0;
    end
    #1;
    check("start_fillAck", {63'd0, fillAck}, {63'd0, withFill});
    @(posedge CB); #1;
    sweepStart = 1'b0; fillReq = 1'b0;
    if (withFill)
      check("fill_before_sweep", {25'd0, arrNow()}, {25'd0, 10'h055, 21'h0ABCDE, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100});
    for (int cyc = 0; cyc < 700 && !finished; cyc++) begin
      if (cyc > 0) begin @(posedge CB); #1; end
      if (tagReadWriteCycle_In && !(cyc == 0 && withFill)) begin
        if (!tagReadNotWrite_In && {writeTagA0, writeTagA1, writeTagB0, writeTagB1} == 4'hF) begin
          if (arrNow() !== {1'b0, expCnt, 1'b0, 21'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF}) idxErr++;
          writes++; lastWr = cyc; expCnt++;
        end else anom++;
      end
      if (sweepBusy) begin
        busyCyc++;
        if (lkupGnt || fillAck) gntErr++;
      end
      if (sweepDone) begin doneCnt++; doneCyc = cyc; end
      if (mode == 0) sweepStart = (writes == 10 && lastWr == cyc);
      if (mode == 1) begin
        if (bistLeft > 0) begin
          if (tagReadWriteCycle_In) bistErr++;
          bistLeft--;
          if (bistLeft == 0) bist_mode = 1'b0;
        end else if (!bistUsed && writes == 100) begin
          bist_mode = 1'b1; bistLeft = 10; bistUsed = 1'b1;
        end
      end
      if (mode == 2 && writes == 50) begin
        resetN = 1'b0;
        #1;
        check("async_reset_mid_sweep", {22'd0, rstBus()}, {22'd0, RST_EXP});
        finished = 1'b1;
      end else if (!sweepBusy && cyc > 0) finished = 1'b1;
    end
    sweepStart = 1'b0;
    check("sweep_terminated", {63'd0, finished}, 64'd1);
    if (mode == 2) begin
      repeat (3) @(posedge CB);
      @(negedge CB); resetN = 1'b1;
      for (int c = 0; c < 300; c++) begin
        @(posedge CB); #1;
        if (sweepBusy || sweepDone || tagReadWriteCycle_In) quiet++;
      end
      check("no_sweep_after_reset", quiet, 0);
      lkupReq = 1'b1; lkupIndex = 10'h0F0;
      #1;
      check("idle_after_reset_gnt", {63'd0, lkupGnt}, 64'd1);
      @(posedge CB); #1;
      lkupReq = 1'b0;
    end else begin
      check("sweep_writes", writes, 256);
      check("sweep_busy_cycles", busyCyc, (mode == 1) ? 268 : 258);
      check("sweep_done_count", doneCnt, 1);
      check("sweep_done_timing", doneCyc, lastWr + 1);
      check("sweep_index_data", idxErr, 0);
      check("sweep_stray_cycles", anom, 0);
      check("sweep_grant_while_busy", gntErr, 0);
      if (mode == 1) begin
        check("bist_no_array_cycle", bistErr, 0);
        check("bist_applied", {63'd0, bistUsed}, 64'd1);
      end
      if (holdLkup) check("lkup_after_sweep", {63'd0, lkupGnt}, 64'd1);
      lkupReq = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(posedge CB); #1;
        if (sweepBusy) quiet++;
      end
      check("no_restart_from_busy_start", quiet, 0);
    end
  endtask

  initial begin
    vt[0] = '{0, 10'h000, 0, 10'h000, 21'h0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 21'h0, 0, 0, 1, 0, 4'b0000};
    vt[1] = '{1, 10'h155, 0, 10'h000, 21'h0, 0, 0, 0, 0, 1, 0, 0, 10'h155, 21'h0, 0, 0, 1, 1, 4'b0000};
    vt[2] = '{1, 10'h3FF, 1, 10'h2AA, 21'h1ABCDE, 1, 1, 1, 0, 0, 1, 1, 10'h2AA, 21'h1ABCDE, 1, 1, 0, 1, 4'b0011};
    vt[3] = '{1, 10'h3FF, 0, 10'h000, 21'h0, 0, 0, 0, 0, 1, 0, 0, 10'h3FF, 21'h1ABCDE, 1, 1, 1, 1, 4'b0000};
    vt[4] = '{0, 10'h000, 1, 10'h001, 21'h000001, 0, 0, 0, 0, 0, 1, 1, 10'h001, 21'h000001, 0, 0, 0, 1, 4'b1100};
    vt[5] = '{0, 10'h000, 0, 10'h000, 21'h0, 0, 0, 0, 0, 0, 0, 0, 10'h001, 21'h000001, 0, 0, 1, 0, 4'b0000};
    vt[6] = '{1, 10'h123, 1, 10'h0F0, 21'h00F0F0, 1, 1, 1, 1, 0, 0, 0, 10'h001, 21'h000001, 0, 0, 1, 0, 4'b0000};
    vt[7] = '{1, 10'h0AB, 0, 10'h000, 21'h0, 0, 0, 0, 0, 1, 0, 0, 10'h0AB, 21'h000001, 0, 0, 1, 1, 4'b0000};
    vt[8] = '{0, 10'h000, 1, 10'h3FF, 21'h1FFFFF, 1, 1, 0, 0, 0, 1, 1, 10'h3FF, 21'h1FFFFF, 1, 0, 0, 1, 4'b0011};

    #2 resetN = 1'b0;
    #1;
    check("reset_outputs", {22'd0, rstBus()}, {22'd0, RST_EXP});
    check("reset_no_grant", {62'd0, lkupGnt, fillAck}, 64'd0);
    repeat (2) @(posedge CB);
    @(negedge CB); resetN = 1'b1;
    @(posedge CB); #1;

    for (int i = 0; i < 9; i++) begin
      lkupReq = vt[i].lr; lkupIndex = vt[i].li;
      fillReq = vt[i].fr; fillIndex = vt[i].fi; fillTag = vt[i].ft;
      fillWay = vt[i].fw; fillValid = vt[i].fv; fillU0 = vt[i].fu; bist_mode = vt[i].bist;
      #1;
      check($sformatf("v%0d_lkupGnt", i), {63'd0, lkupGnt}, {63'd0, vt[i].eGnt});
      check($sformatf("v%0d_fillAck", i), {63'd0, fillAck}, {63'd0, vt[i].eAck});
      @(posedge CB); #1;
      check($sformatf("v%0d_lkupRdy", i), {63'd0, lkupRdy}, {63'd0, vt[i].eRdy});
      check($sformatf("v%0d_array", i), {25'd0, arrNow()},
            {25'd0, vt[i].eTag, vt[i].eData, vt[i].eNv, vt[i].eU0, vt[i].eRnw, vt[i].eRwc, vt[i].eWr});
    end
    idleIn();
    repeat (2) @(posedge CB);
    #1;

    sweepRun(0, 1'b0, 1'b1);
    sweepRun(0, 1'b1, 1'b0);
    sweepRun(1, 1'b0, 1'b0);
    sweepRun(2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
